// File: rtl/verificador_disparo.sv
// Shot checker for the 5x7 ship map: classifies each confirmed shot, keeps shot masks and score.
// Build option REPETIDO_GASTA_EN: a repeated shot also costs one shot.
module verificador_disparo #(
  parameter int MAX_TIROS = 20,
  parameter int CONT_W    = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [6:0]        mapa0,
  input  logic [6:0]        mapa1,
  input  logic [6:0]        mapa2,
  input  logic [6:0]        mapa3,
  input  logic [6:0]        mapa4,
  input  logic [2:0]        linha,
  input  logic [2:0]        coluna,
  input  logic              confirmar,
  output logic              acerto,
  output logic              erro,
  output logic              repetido,
  output logic              invalido,
  output logic [6:0]        tiros0,
  output logic [6:0]        tiros1,
  output logic [6:0]        tiros2,
  output logic [6:0]        tiros3,
  output logic [6:0]        tiros4,
  output logic [CONT_W-1:0] acertos,
  output logic [CONT_W-1:0] tiros_restantes,
  output logic              vitoria,
  output logic              derrota
);

  // state   | meaning
  // OCIOSO  | game phase off, outputs hold
  // CARREGA | one cycle: clear score, count ship cells
  // JOGANDO | waiting for a confirmar press
  // AVALIA  | classify the latched shot
  // VITORIA | all ship cells hit, frozen
  // DERROTA | shots exhausted, frozen
  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] CARREGA = 3'd1;
  localparam logic [2:0] JOGANDO = 3'd2;
  localparam logic [2:0] AVALIA  = 3'd3;
  localparam logic [2:0] VITORIA = 3'd4;
  localparam logic [2:0] DERROTA = 3'd5;

  logic [2:0]       estado, prox;
  logic             conf_s1, conf_s2, conf_ant, enable_ant;
  logic             conf_borda, en_sobe;
  logic [2:0]       lin_q, col_q;
  logic [5:0]       total_navios, contagem;
  logic [4:0][6:0]  tiros_q;
  logic [6:0]       linha_mapa, linha_tiros, mascara_col;
  logic [7:0]       mapa_ext, tiros_ext;
  logic             fora, ja_atirado, navio;
  logic             c_acerto, c_erro, c_repetido, c_invalido, gasta;
  logic [CONT_W-1:0] acertos_nxt, rest_nxt;
  logic             ganhou;

  function automatic logic [5:0] conta_uns(input logic [34:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 35; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  assign contagem    = conta_uns({mapa4, mapa3, mapa2, mapa1, mapa0});
  assign conf_borda  = conf_s2 & ~conf_ant;
  assign en_sobe     = enable & ~enable_ant;
  assign mascara_col = 7'b1 << col_q;

  always_comb begin
    linha_mapa  = '0;
    linha_tiros = '0;
    case (lin_q)
      3'd0: begin linha_mapa = mapa0; linha_tiros = tiros_q[0]; end
      3'd1: begin linha_mapa = mapa1; linha_tiros = tiros_q[1]; end
      3'd2: begin linha_mapa = mapa2; linha_tiros = tiros_q[2]; end
      3'd3: begin linha_mapa = mapa3; linha_tiros = tiros_q[3]; end
      3'd4: begin linha_mapa = mapa4; linha_tiros = tiros_q[4]; end
      default: ;
    endcase
  end

  // Column 7 lands on the padding bit; it is already flagged invalid anyway.
  assign mapa_ext   = {1'b0, linha_mapa};
  assign tiros_ext  = {1'b0, linha_tiros};
  assign fora       = (lin_q > 3'd4) || (col_q > 3'd6);
  assign ja_atirado = tiros_ext[col_q];
  assign navio      = mapa_ext[col_q];

  always_comb begin
    c_acerto   = 1'b0;
    c_erro     = 1'b0;
    c_repetido = 1'b0;
    c_invalido = 1'b0;
    if (fora)            c_invalido = 1'b1;
    else if (ja_atirado) c_repetido = 1'b1;
    else if (navio)      c_acerto   = 1'b1;
    else                 c_erro     = 1'b1;
`ifdef REPETIDO_GASTA_EN
    gasta = c_acerto | c_erro | c_repetido;
`else
    gasta = c_acerto | c_erro;
`endif
    acertos_nxt = acertos + CONT_W'(c_acerto);
    rest_nxt    = (gasta && (tiros_restantes != '0)) ? tiros_restantes - CONT_W'(1)
                                                     : tiros_restantes;
    ganhou      = (int'(acertos_nxt) == int'(total_navios));
  end

  always_comb begin
    prox = estado;
    if (!enable) begin
      prox = OCIOSO;
    end else begin
      case (estado)
        OCIOSO:  if (en_sobe) prox = CARREGA;
        CARREGA: prox = (contagem == '0) ? VITORIA : JOGANDO;
        JOGANDO: if (conf_borda) prox = AVALIA;
        AVALIA: begin
          if (ganhou)                prox = VITORIA;
          else if (rest_nxt == '0)   prox = DERROTA;
          else                       prox = JOGANDO;
        end
        VITORIA: prox = VITORIA;
        DERROTA: prox = DERROTA;
        default: prox = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado          <= OCIOSO;
      conf_s1         <= 1'b0;
      conf_s2         <= 1'b0;
      conf_ant        <= 1'b0;
      enable_ant      <= 1'b0;
      lin_q           <= '0;
      col_q           <= '0;
      total_navios    <= '0;
      tiros_q         <= '0;
      acertos         <= '0;
      tiros_restantes <= CONT_W'(MAX_TIROS);
      vitoria         <= 1'b0;
      derrota         <= 1'b0;
      acerto          <= 1'b0;
      erro            <= 1'b0;
      repetido        <= 1'b0;
      invalido        <= 1'b0;
    end else begin
      estado     <= prox;
      conf_s1    <= confirmar;
      conf_s2    <= conf_s1;
      conf_ant   <= conf_s2;
      enable_ant <= enable;
      acerto     <= 1'b0;
      erro       <= 1'b0;
      repetido   <= 1'b0;
      invalido   <= 1'b0;
      case (estado)
        CARREGA: if (enable) begin
          tiros_q         <= '0;
          acertos         <= '0;
          tiros_restantes <= CONT_W'(MAX_TIROS);
          total_navios    <= contagem;
          vitoria         <= (contagem == '0);
          derrota         <= 1'b0;
        end
        JOGANDO: if (conf_borda) begin
          lin_q <= linha;
          col_q <= coluna;
        end
        // Dropping enable here discards the shot entirely.
        AVALIA: if (enable) begin
          acerto          <= c_acerto;
          erro            <= c_erro;
          repetido        <= c_repetido;
          invalido        <= c_invalido;
          acertos         <= acertos_nxt;
          tiros_restantes <= rest_nxt;
          vitoria         <= ganhou;
          derrota         <= !ganhou && (rest_nxt == '0);
          if (c_acerto || c_erro) begin
            for (int r = 0; r < 5; r++)
              if (lin_q == 3'(r)) tiros_q[r] <= tiros_q[r] | mascara_col;
          end
        end
        default: ;
      endcase
    end
  end

  assign tiros0 = tiros_q[0];
  assign tiros1 = tiros_q[1];
  assign tiros2 = tiros_q[2];
  assign tiros3 = tiros_q[3];
  assign tiros4 = tiros_q[4];

endmodule

// File: tb/tb_verificador_disparo.sv
// Scoreboard bench for verificador_disparo: a small game model predicts each pulse and score.
module tb_verificador_disparo;

  logic       clock, reset_n, enable, enable3, confirmar;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic [2:0] linha, coluna;
  logic       acerto, erro, repetido, invalido, vitoria, derrota;
  logic [6:0] tiros0, tiros1, tiros2, tiros3, tiros4;
  logic [4:0] acertos, tiros_restantes;
  logic       acerto3, erro3, repetido3, invalido3, vitoria3, derrota3;
  logic [6:0] t30, t31, t32, t33, t34;
  logic [4:0] acertos3, rest3;

  int total = 0;
  int bad   = 0;
  int pulsos3 = 0;

  typedef struct {
    logic [3:0] tipo;
    logic [4:0] acertos;
    logic [4:0] rest;
    int         lin;
    logic [6:0] mask;
  } esperado_t;

  esperado_t fila[$];
  esperado_t e_mon;

  logic [6:0] mdl_mapa [5];
  logic [6:0] mdl_tiros[5];
  int mdl_acertos, mdl_rest;

  verificador_disparo dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
    .linha(linha), .coluna(coluna), .confirmar(confirmar),
    .acerto(acerto), .erro(erro), .repetido(repetido), .invalido(invalido),
    .tiros0(tiros0), .tiros1(tiros1), .tiros2(tiros2), .tiros3(tiros3), .tiros4(tiros4),
    .acertos(acertos), .tiros_restantes(tiros_restantes),
    .vitoria(vitoria), .derrota(derrota)
  );

  verificador_disparo #(.MAX_TIROS(3), .CONT_W(5)) dut3 (
    .clock(clock), .reset_n(reset_n), .enable(enable3),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
    .linha(linha), .coluna(coluna), .confirmar(confirmar),
    .acerto(acerto3), .erro(erro3), .repetido(repetido3), .invalido(invalido3),
    .tiros0(t30), .tiros1(t31), .tiros2(t32), .tiros3(t33), .tiros4(t34),
    .acertos(acertos3), .tiros_restantes(rest3),
    .vitoria(vitoria3), .derrota(derrota3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] linha_dut(input int l);
    case (l)
      0: return tiros0;
      1: return tiros1;
      2: return tiros2;
      3: return tiros3;
      default: return tiros4;
    endcase
  endfunction

  // Scoreboard consumer: every pulse must match the oldest prediction.
  always @(negedge clock) begin
    if (reset_n && (acerto | erro | repetido | invalido)) begin
      if (fila.size() == 0) begin
        checa("pulso_inesperado", {28'd0, acerto, erro, repetido, invalido}, 32'd0);
      end else begin
        e_mon = fila.pop_front();
        checa("tipo", {28'd0, acerto, erro, repetido, invalido}, {28'd0, e_mon.tipo});
        checa("acertos", {27'd0, acertos}, {27'd0, e_mon.acertos});
        checa("restantes", {27'd0, tiros_restantes}, {27'd0, e_mon.rest});
        checa("mascara", {25'd0, linha_dut(e_mon.lin)}, {25'd0, e_mon.mask});
      end
    end
    if (reset_n && (acerto3 | erro3 | repetido3 | invalido3)) pulsos3++;
  end

  task automatic ciclos(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic novo_jogo();
    mdl_mapa[0] = mapa0; mdl_mapa[1] = mapa1; mdl_mapa[2] = mapa2;
    mdl_mapa[3] = mapa3; mdl_mapa[4] = mapa4;
    for (int r = 0; r < 5; r++) mdl_tiros[r] = '0;
    mdl_acertos = 0;
    mdl_rest    = 20;
  endtask

  task automatic pulsa(input int l, input int c, input int hold);
    linha     = 3'(l);
    coluna    = 3'(c);
    confirmar = 1'b1;
    ciclos(hold);
    confirmar = 1'b0;
    ciclos(8);
  endtask

  task automatic dispara(input int l, input int c, input int hold);
    esperado_t e;
    if (l > 4 || c > 6) begin
      e.tipo = 4'b0001;
    end else if (mdl_tiros[l][c]) begin
      e.tipo = 4'b0010;
`ifdef REPETIDO_GASTA_EN
      if (mdl_rest > 0) mdl_rest--;
`endif
    end else if (mdl_mapa[l][c]) begin
      e.tipo = 4'b1000;
      mdl_tiros[l][c] = 1'b1;
      mdl_acertos++;
      mdl_rest--;
    end else begin
      e.tipo = 4'b0100;
      mdl_tiros[l][c] = 1'b1;
      mdl_rest--;
    end
    e.acertos = 5'(mdl_acertos);
    e.rest    = 5'(mdl_rest);
    e.lin     = (l <= 4) ? l : 0;
    e.mask    = mdl_tiros[e.lin];
    fila.push_back(e);
    pulsa(l, c, hold);
  endtask

  task automatic mapa_principal();
    mapa0 = 7'b0000100; mapa1 = 7'b0001100; mapa2 = 7'b1000101;
    mapa3 = 7'b1110001; mapa4 = 7'b1000011;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; enable3 = 1'b0; confirmar = 1'b0;
    linha = '0; coluna = '0;
    mapa0 = '0; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    ciclos(3);
    checa("rst_acertos", {27'd0, acertos}, 32'd0);
    checa("rst_restantes", {27'd0, tiros_restantes}, 32'd20);
    checa("rst_tiros", {25'd0, tiros0 | tiros1 | tiros2 | tiros3 | tiros4}, 32'd0);
    checa("rst_fim", {30'd0, vitoria, derrota}, 32'd0);
    checa("rst_pulsos", {28'd0, acerto, erro, repetido, invalido}, 32'd0);
    reset_n = 1'b1;
    ciclos(2);

    // main map: 13 ship cells
    mapa_principal();
    enable = 1'b1;
    novo_jogo();
    ciclos(4);
    checa("jogo_vitoria0", {31'd0, vitoria}, 32'd0);
    dispara(0, 2, 4);
    checa("tiros0", {25'd0, tiros0}, 32'b0000100);
    dispara(0, 0, 4);
    dispara(0, 0, 4);
    dispara(5, 1, 4);
    dispara(2, 7, 4);
    dispara(1, 3, 4);
    checa("placar_acertos", {27'd0, acertos}, 32'(mdl_acertos));
    checa("placar_rest", {27'd0, tiros_restantes}, 32'(mdl_rest));

    // asynchronous reset mid-game
    #2 reset_n = 1'b0;
    #1;
    checa("mid_acertos", {27'd0, acertos}, 32'd0);
    checa("mid_restantes", {27'd0, tiros_restantes}, 32'd20);
    checa("mid_tiros", {25'd0, tiros0 | tiros1 | tiros2 | tiros3 | tiros4}, 32'd0);
    enable = 1'b0;
    ciclos(2);
    checa("mid_pulsos", {28'd0, acerto, erro, repetido, invalido}, 32'd0);
    reset_n = 1'b1;
    ciclos(2);

    // empty map wins two cycles after enable rises
    mapa0 = '0; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    enable = 1'b1;
    ciclos(1);
    checa("vazio_ciclo1", {31'd0, vitoria}, 32'd0);
    ciclos(1);
    checa("vazio_ciclo2", {31'd0, vitoria}, 32'd1);
    pulsa(0, 0, 4);
    enable = 1'b0;
    ciclos(2);

    // single ship cell
    mapa2 = 7'b0000001;
    enable = 1'b1;
    novo_jogo();
    ciclos(4);
    checa("um_vitoria0", {31'd0, vitoria}, 32'd0);
    dispara(2, 0, 4);
    checa("um_vitoria1", {31'd0, vitoria}, 32'd1);
    checa("um_derrota", {31'd0, derrota}, 32'd0);
    pulsa(2, 1, 4);
    enable = 1'b0;
    ciclos(2);

    // long press gives one event; enable drop during AVALIA discards it
    mapa_principal();
    enable = 1'b1;
    novo_jogo();
    ciclos(4);
    dispara(1, 3, 50);
    linha = 3'd1; coluna = 3'd2;
    confirmar = 1'b1;
    repeat (3) @(posedge clock);
    #1 enable = 1'b0;
    ciclos(6);
    checa("drop_acertos", {27'd0, acertos}, 32'(mdl_acertos));
    checa("drop_rest", {27'd0, tiros_restantes}, 32'(mdl_rest));
    checa("drop_tiros1", {25'd0, tiros1}, {25'd0, mdl_tiros[1]});
    // press still held while the new game starts
    enable = 1'b1;
    novo_jogo();
    ciclos(10);
    confirmar = 1'b0;
    ciclos(4);
    dispara(1, 2, 4);
    enable = 1'b0;
    ciclos(2);

    // three-shot instance: three misses then a refused fourth press
    enable3 = 1'b1;
    ciclos(4);
    pulsa(0, 0, 4);
    pulsa(0, 1, 4);
    checa("d3_derrota_cedo", {31'd0, derrota3}, 32'd0);
    pulsa(0, 3, 4);
    checa("d3_derrota", {31'd0, derrota3}, 32'd1);
    checa("d3_vitoria", {31'd0, vitoria3}, 32'd0);
    checa("d3_rest", {27'd0, rest3}, 32'd0);
    checa("d3_tiros0", {25'd0, t30}, 32'b0001011);
    checa("d3_pulsos", 32'(pulsos3), 32'd3);
    pulsa(0, 4, 4);
    checa("d3_quarto", 32'(pulsos3), 32'd3);
    enable3 = 1'b0;
    ciclos(2);

    checa("fila_vazia", 32'(fila.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
